// File: rtl/uart_ctrl_seq.sv
// uart_ctrl_seq: master sequencer for the 8-bit uart_regs register port.
// Programs DLL/DLM/LCR/FCR/IER after init, then polls LSR and arbitrates
// the port round-robin between a TX byte stream and an RX byte stream.
//
// Ports:
//   i_clk, i_wb_rst          clock, synchronous active-high reset
//   i_init_start             starts / restarts the init sequence
//   o_init_done, o_busy      configured / sequencing status
//   i_tx_valid, i_tx_data    producer byte; o_tx_ready pulses on THR write
//   o_rx_valid, o_rx_data    consumer byte, held until i_rx_ready
//   o_reg_addr, o_reg_dat    uart_regs address / write data
//   o_reg_we, o_reg_re       one-cycle write / read strobes
//   i_reg_dat                uart_regs read data, valid cycle after o_reg_re
module uart_ctrl_seq #(
   parameter logic [15:0] DIVISOR = 16'd27,
   parameter logic [7:0]  LCR_VAL = 8'h03,
   parameter logic [7:0]  FCR_VAL = 8'hC7,
   parameter logic [7:0]  IER_VAL = 8'h00
) (
   input  logic       i_clk,
   input  logic       i_wb_rst,
   input  logic       i_init_start,
   output logic       o_init_done,
   output logic       o_busy,
   input  logic       i_tx_valid,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_ready,
   output logic       o_rx_valid,
   output logic [7:0] o_rx_data,
   input  logic       i_rx_ready,
   output logic [2:0] o_reg_addr,
   output logic [7:0] o_reg_dat,
   output logic       o_reg_we,
   output logic       o_reg_re,
   input  logic [7:0] i_reg_dat
);

   localparam logic [2:0] A_DAT = 3'd0;
   localparam logic [2:0] A_IER = 3'd1;
   localparam logic [2:0] A_FCR = 3'd2;
   localparam logic [2:0] A_LCR = 3'd3;
   localparam logic [2:0] A_LSR = 3'd5;

   // Side served last by the arbiter.
   localparam logic RR_RX = 1'b0;
   localparam logic RR_TX = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_W_LCRD  = 4'd1,
      S_W_DLL   = 4'd2,
      S_W_DLM   = 4'd3,
      S_W_LCR   = 4'd4,
      S_W_FCR   = 4'd5,
      S_W_IER   = 4'd6,
      S_READY   = 4'd7,
      S_RD_LSR  = 4'd8,
      S_LSR_CAP = 4'd9,
      S_RD_RBR  = 4'd10,
      S_RBR_CAP = 4'd11,
      S_W_THR   = 4'd12
   } state_t;

   state_t     r_state;
   state_t     w_nxt;
   logic       r_rx_valid;
   logic [7:0] r_rx_data;
   logic       r_rr_last;

   logic       w_can_rx;
   logic       w_can_tx;

   // LSR is only meaningful in S_LSR_CAP, one cycle after the read strobe.
   assign w_can_rx = i_reg_dat[0] & ~r_rx_valid;
   assign w_can_tx = i_reg_dat[5] & i_tx_valid;

   assign o_rx_valid = r_rx_valid;
   assign o_rx_data  = r_rx_data;

   always_ff @(posedge i_clk) begin
      if (i_wb_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wb_rst) begin
         r_rx_valid <= 1'b0;
         r_rx_data  <= 8'h00;
         r_rr_last  <= RR_RX;
      end else begin
         if (r_state == S_RBR_CAP) begin
            r_rx_data  <= i_reg_dat;
            r_rx_valid <= 1'b1;
            r_rr_last  <= RR_RX;
         end else if (r_rx_valid && i_rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         if (r_state == S_W_THR) begin
            r_rr_last <= RR_TX;
         end
      end
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (i_init_start) w_nxt = S_W_LCRD;
         end
         S_W_LCRD: w_nxt = S_W_DLL;
         S_W_DLL:  w_nxt = S_W_DLM;
         S_W_DLM:  w_nxt = S_W_LCR;
         S_W_LCR:  w_nxt = S_W_FCR;
         S_W_FCR:  w_nxt = S_W_IER;
         S_W_IER:  w_nxt = S_READY;
         S_READY: begin
            if (i_init_start) begin
               w_nxt = S_W_LCRD;
            end else if (i_tx_valid || !r_rx_valid) begin
               w_nxt = S_RD_LSR;
            end
         end
         S_RD_LSR: w_nxt = S_LSR_CAP;
         S_LSR_CAP: begin
            // Contention goes to the side not served last time.
            if (w_can_rx && w_can_tx) begin
               w_nxt = (r_rr_last == RR_TX) ? S_RD_RBR : S_W_THR;
            end else if (w_can_rx) begin
               w_nxt = S_RD_RBR;
            end else if (w_can_tx) begin
               w_nxt = S_W_THR;
            end else begin
               w_nxt = S_READY;
            end
         end
         S_RD_RBR:  w_nxt = S_RBR_CAP;
         S_RBR_CAP: w_nxt = S_READY;
         S_W_THR:   w_nxt = S_READY;
         default:   w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_reg_addr  = 3'd0;
      o_reg_dat   = 8'h00;
      o_reg_we    = 1'b0;
      o_reg_re    = 1'b0;
      o_tx_ready  = 1'b0;
      o_init_done = 1'b0;
      o_busy      = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
         end
         S_W_LCRD: begin
            // DLAB set so addresses 0/1 reach the divisor latch.
            o_reg_we   = 1'b1;
            o_reg_addr = A_LCR;
            o_reg_dat  = LCR_VAL | 8'h80;
         end
         S_W_DLL: begin
            o_reg_we   = 1'b1;
            o_reg_addr = A_DAT;
            o_reg_dat  = DIVISOR[7:0];
         end
         S_W_DLM: begin
            o_reg_we   = 1'b1;
            o_reg_addr = A_IER;
            o_reg_dat  = DIVISOR[15:8];
         end
         S_W_LCR: begin
            o_reg_we   = 1'b1;
            o_reg_addr = A_LCR;
            o_reg_dat  = LCR_VAL & 8'h7F;
         end
         S_W_FCR: begin
            o_reg_we   = 1'b1;
            o_reg_addr = A_FCR;
            o_reg_dat  = FCR_VAL;
         end
         S_W_IER: begin
            o_reg_we   = 1'b1;
            o_reg_addr = A_IER;
            o_reg_dat  = IER_VAL;
         end
         S_READY: begin
            o_busy      = 1'b0;
            o_init_done = 1'b1;
         end
         S_RD_LSR: begin
            o_init_done = 1'b1;
            o_reg_re    = 1'b1;
            o_reg_addr  = A_LSR;
         end
         S_LSR_CAP: begin
            o_init_done = 1'b1;
         end
         S_RD_RBR: begin
            o_init_done = 1'b1;
            o_reg_re    = 1'b1;
            o_reg_addr  = A_DAT;
         end
         S_RBR_CAP: begin
            o_init_done = 1'b1;
         end
         S_W_THR: begin
            o_init_done = 1'b1;
            o_reg_we    = 1'b1;
            o_reg_addr  = A_DAT;
            o_reg_dat   = i_tx_data;
            o_tx_ready  = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
   end

endmodule
